lpm_table_engine: RTL and testbench
===================================

Name: lpm_table_engine

Overview:
- Routing-table responder for the output-port-lookup header stage: holds the 32-entry LPM table and answers the header stage's destination-IP queries with lpm_hit, next hop and output queue.
- Sits beside the header stage inside the output port lookup pcore. The header stage issues a request per IPv4 packet and consumes lpm_hit / nh_out / oq_out.
- Host software fills the table through a register read/write port driven by the AXI-Lite register block.
- Lookup is a sequential scan, one entry per cycle, with a fixed latency.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of the IP, mask, next-hop and OQ fields.
- TABLE_DEPTH, 32, number of table entries.
- ADDR_BITS, 5, table address width (log2 TABLE_DEPTH).

Ports:
- AXI_ACLK  in  1  clock.
- reset  in  1  synchronous, active-high reset; clock AXI_ACLK.
- lookup_req  in  1  start a lookup; accepted only when lookup_ready=1.
- lookup_ip  in  32  destination IP, sampled on the accept cycle.
- lookup_ready  out  1  engine idle and able to accept a request.
- lookup_done  out  1  one-cycle pulse when the result is valid.
- lpm_hit  out  1  a valid matching entry was found.
- nh_out  out  32  next-hop IP.
- oq_out  out  32  output queue index.
- tbl_wr_req  in  1  table write strobe.
- tbl_wr_addr  in  ADDR_BITS  write address.
- tbl_wr_data  in  128  entry {ip[127:96], mask[95:64], next_hop[63:32], oq[31:0]}.
- tbl_wr_ack  out  1  one-cycle pulse, one cycle after the write.
- tbl_rd_req  in  1  table read strobe.
- tbl_rd_addr  in  ADDR_BITS  read address.
- tbl_rd_data  out  128  entry read back.
- tbl_rd_ack  out  1  one-cycle pulse, coincident with valid tbl_rd_data.

Behaviour:
- Reset values: every table entry = 128'hFFFF…F; lookup_ready=1; lookup_done=0; lpm_hit=0; nh_out=0; oq_out=0; tbl_wr_ack=0; tbl_rd_ack=0; tbl_rd_data=0; FSM in IDLE.
- A reset asserted mid-scan aborts the scan. No lookup_done is produced.
- Entry valid rule: an entry is valid iff oq != 32'hFFFFFFFF. Writing an entry with that oq value deletes it.
- Match rule: entry matches iff (lookup_ip & mask) == (ip & mask) and the entry is valid. Mask 0 is a default route and matches any address.
- Longest prefix: the best candidate is replaced only when a match has mask strictly greater (unsigned) than the current best mask. Masks are contiguous by software contract.
  - Equal masks: the lowest index wins.
  - A first match always sets the best, including a mask-0 match.
- FSM IDLE: lookup_ready=1. On lookup_req:
  - latch lookup_ip;
  - clear best-hit flag, best mask, best next hop, best OQ;
  - index=0; go to SCAN.
- FSM SCAN: lookup_ready=0. Evaluate entry[index] each cycle. When index == TABLE_DEPTH-1, go to DONE; otherwise index+1.
- FSM DONE: register lpm_hit, nh_out, oq_out; pulse lookup_done for one cycle; return to IDLE.
- Latency: request accepted in cycle T gives lookup_done in cycle T+TABLE_DEPTH+1 (33 at default). lookup_ready is high again in cycle T+TABLE_DEPTH+2.
- Hit result:
  - nh_out = best next hop, or the latched lookup_ip if the best next hop == 0 (directly connected network).
  - oq_out = best oq.
- Miss result: lpm_hit=0, nh_out=0, oq_out=0.
- Result hold: lpm_hit, nh_out and oq_out hold their value until the next DONE, so the consumer may sample them any time after lookup_done.
- lookup_req while busy is ignored: no queueing and no error.
- Table writes are accepted in any state, including during SCAN, and land at the clock edge. A scan uses the contents of each entry at the cycle that entry is evaluated: writes to already-scanned entries do not affect the current result, writes to unscanned entries do.
- Table reads: tbl_rd_data is registered, and tbl_rd_ack pulses the cycle after tbl_rd_req. A read and a write to the same address in the same cycle returns the old data.
- tbl_wr_req and tbl_rd_req may be asserted in the same cycle; both are serviced, each with its own ack.
- Out-of-range addresses cannot occur because TABLE_DEPTH = 2^ADDR_BITS.

Decomposition:
- Shared package holds:
  - the entry field bit positions (IP 127:96, MASK 95:64, NH 63:32, OQ 31:0);
  - INVALID_OQ = 32'hFFFFFFFF;
  - the FSM state encodings IDLE=0, SCAN=1, DONE=2.
- Sub-module lpm_match_cmp: combinational match plus longer-prefix compare.
  - Inputs: entry, lookup_ip, current best mask, best-valid flag.
  - Output: replace flag.
- The top level holds the table storage, the FSM, and the read/write port logic.

Test Plan:
- After reset, read all 32 entries -> each returns 128'hFFFF…F with tbl_rd_ack one cycle after tbl_rd_req. Then look up 10.0.0.1 -> lookup_done at T+33 with lpm_hit=0, nh=0, oq=0.
- Entry 3 = {10.0.0.0, 255.0.0.0, 0, 1}, entry 7 = {10.1.0.0, 255.255.0.0, 192.168.1.1, 2}:
  - lookup 10.1.2.3 -> hit, nh=192.168.1.1, oq=2;
  - lookup 10.9.9.9 -> hit, nh=10.9.9.9, oq=1.
- Default route entry 0 = {0, 0, 1.1.1.1, 4}, entry 5 = {20.0.0.0, 255.0.0.0, 0, 3}: lookup 30.0.0.1 -> oq=4, nh=1.1.1.1.
- Tie: entries 2 and 9 both {10.0.0.0, 255.0.0.0}, with oq 1 and 3 -> lookup 10.5.5.5 -> oq=1 (lowest index wins).
- Mid-scan behaviour:
  - a second lookup_req at T+5 is ignored (exactly one lookup_done);
  - writing entry 30 with a /32 match at T+10 changes the result to that entry;
  - writing entry 1 at T+10 does not change the result.
- Assert reset at T+15 -> no lookup_done, lookup_ready=1 next cycle, table back to all-F.

Source files
------------

// File: rtl/lpm_table_engine_pkg.sv
// Shared definitions for the LPM table engine: entry layout, invalid-OQ marker, FSM states.
package lpm_table_engine_pkg;

  localparam int ENTRY_W = 128;
  localparam int IP_HI   = 127;
  localparam int IP_LO   = 96;
  localparam int MASK_HI = 95;
  localparam int MASK_LO = 64;
  localparam int NH_HI   = 63;
  localparam int NH_LO   = 32;
  localparam int OQ_HI   = 31;
  localparam int OQ_LO   = 0;

  localparam logic [31:0] INVALID_OQ = 32'hFFFF_FFFF;

  // Field order mirrors the bit positions above, ip in the top word.
  typedef struct packed {
    logic [31:0] ip;
    logic [31:0] mask;
    logic [31:0] nh;
    logic [31:0] oq;
  } lpm_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lpm_state_e;

endpackage

// File: rtl/lpm_table_engine_match_cmp.sv
// Combinational match test of one entry plus the longer-prefix decision against the current best.
module lpm_match_cmp
  import lpm_table_engine_pkg::*;
(
  input  lpm_entry_t  entry,
  input  logic [31:0] lookup_ip,
  input  logic [31:0] best_mask,
  input  logic        best_vld,
  output logic        replace
);

  logic valid;
  logic match;

  assign valid   = (entry.oq != INVALID_OQ);
  assign match   = (((lookup_ip ^ entry.ip) & entry.mask) == 32'd0);
  // Strict compare keeps the lowest index on equal masks.
  assign replace = valid && match && (!best_vld || (entry.mask > best_mask));

endmodule

// File: rtl/lpm_table_engine.sv
// 32-entry LPM routing table with a sequential one-entry-per-cycle lookup and a host read/write port.
module lpm_table_engine
  import lpm_table_engine_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TABLE_DEPTH        = 32,
  parameter int ADDR_BITS          = 5
) (
  input  logic                            AXI_ACLK,
  input  logic                            reset,
  input  logic                            lookup_req,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   lookup_ip,
  output logic                            lookup_ready,
  output logic                            lookup_done,
  output logic                            lpm_hit,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   nh_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   oq_out,
  input  logic                            tbl_wr_req,
  input  logic [ADDR_BITS-1:0]            tbl_wr_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  output logic                            tbl_wr_ack,
  input  logic                            tbl_rd_req,
  input  logic [ADDR_BITS-1:0]            tbl_rd_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  output logic                            tbl_rd_ack
);

  lpm_entry_t tbl [TABLE_DEPTH];

  lpm_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          ip_q;
  logic                 best_vld;
  logic [31:0]          best_mask, best_nh, best_oq;

  lpm_entry_t  cur;
  logic        replace, start, last;
  logic        fin_vld;
  logic [31:0] fin_nh, fin_oq;

  assign cur   = tbl[idx];
  assign start = (state_q == IDLE) && lookup_req;
  assign last  = (idx == ADDR_BITS'(TABLE_DEPTH - 1));

  lpm_match_cmp u_cmp (
    .entry     (cur),
    .lookup_ip (ip_q),
    .best_mask (best_mask),
    .best_vld  (best_vld),
    .replace   (replace)
  );

  // Final entry's verdict folded in so the result is registered on entry into DONE.
  assign fin_vld = best_vld | replace;
  assign fin_nh  = replace ? cur.nh : best_nh;
  assign fin_oq  = replace ? cur.oq : best_oq;

  always_ff @(posedge AXI_ACLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    lookup_ready = 1'b0;
    lookup_done  = 1'b0;
    case (state_q)
      IDLE: begin
        lookup_ready = 1'b1;
        if (lookup_req) state_d = SCAN;
      end
      SCAN: if (last) state_d = DONE;
      DONE: begin
        lookup_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      idx       <= '0;
      ip_q      <= '0;
      best_vld  <= 1'b0;
      best_mask <= '0;
      best_nh   <= '0;
      best_oq   <= '0;
      lpm_hit   <= 1'b0;
      nh_out    <= '0;
      oq_out    <= '0;
    end else if (start) begin
      ip_q      <= lookup_ip;
      idx       <= '0;
      best_vld  <= 1'b0;
      best_mask <= '0;
      best_nh   <= '0;
      best_oq   <= '0;
    end else if (state_q == SCAN) begin
      idx <= idx + 1'b1;
      if (replace) begin
        best_vld  <= 1'b1;
        best_mask <= cur.mask;
        best_nh   <= cur.nh;
        best_oq   <= cur.oq;
      end
      if (last) begin
        lpm_hit <= fin_vld;
        // Zero next hop means directly connected: forward to the destination itself.
        nh_out  <= !fin_vld ? '0 : (fin_nh == 32'd0) ? ip_q : fin_nh;
        oq_out  <= fin_vld ? fin_oq : '0;
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) tbl[i] <= '1;
    end else if (tbl_wr_req) begin
      tbl[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      tbl_wr_ack  <= 1'b0;
      tbl_rd_ack  <= 1'b0;
      tbl_rd_data <= '0;
    end else begin
      tbl_wr_ack <= tbl_wr_req;
      tbl_rd_ack <= tbl_rd_req;
      if (tbl_rd_req) tbl_rd_data <= tbl[tbl_rd_addr];
    end
  end

endmodule

// File: tb/tb_lpm_table_engine.sv
// Directed bench for lpm_table_engine: table port, LPM results, latency, mid-scan writes and reset.
module tb_lpm_table_engine;

  logic         AXI_ACLK;
  logic         reset;
  logic         lookup_req;
  logic [31:0]  lookup_ip;
  logic         lookup_ready, lookup_done, lpm_hit;
  logic [31:0]  nh_out, oq_out;
  logic         tbl_wr_req;
  logic [4:0]   tbl_wr_addr;
  logic [127:0] tbl_wr_data;
  logic         tbl_wr_ack;
  logic         tbl_rd_req;
  logic [4:0]   tbl_rd_addr;
  logic [127:0] tbl_rd_data;
  logic         tbl_rd_ack;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] ALL_F = {128{1'b1}};

  lpm_table_engine dut (
    .AXI_ACLK     (AXI_ACLK),
    .reset        (reset),
    .lookup_req   (lookup_req),
    .lookup_ip    (lookup_ip),
    .lookup_ready (lookup_ready),
    .lookup_done  (lookup_done),
    .lpm_hit      (lpm_hit),
    .nh_out       (nh_out),
    .oq_out       (oq_out),
    .tbl_wr_req   (tbl_wr_req),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
    .tbl_wr_ack   (tbl_wr_ack),
    .tbl_rd_req   (tbl_rd_req),
    .tbl_rd_addr  (tbl_rd_addr),
    .tbl_rd_data  (tbl_rd_data),
    .tbl_rd_ack   (tbl_rd_ack)
  );

  initial AXI_ACLK = 1'b0;
  always #5 AXI_ACLK = ~AXI_ACLK;

  function automatic logic [127:0] ent(input logic [31:0] ip, m, nh, oq);
    return {ip, m, nh, oq};
  endfunction

  task automatic wr(input int a, input logic [127:0] d);
    @(negedge AXI_ACLK);
    tbl_wr_req  = 1'b1;
    tbl_wr_addr = a[4:0];
    tbl_wr_data = d;
    @(negedge AXI_ACLK);
    tbl_wr_req  = 1'b0;
  endtask

  // Drives one lookup, optionally with a stray request, a table write or a reset at cycle T+n.
  task automatic run_lookup(input logic [31:0] ip, input int req2_at, input int wr_at,
                            input int wa, input logic [127:0] wd, input int rst_at,
                            output int ndone, output int done_at, output logic rdy_after,
                            output logic hit, output logic [31:0] nh, output logic [31:0] oq,
                            output logic rdy_post_rst);
    @(negedge AXI_ACLK);
    lookup_req = 1'b1;
    lookup_ip  = ip;
    ndone = 0; done_at = -1; rdy_after = 1'b0; rdy_post_rst = 1'b0;
    hit = 1'b0; nh = '0; oq = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge AXI_ACLK);
      if (lookup_done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = n; hit = lpm_hit; nh = nh_out; oq = oq_out;
        end
      end
      if (done_at > 0 && n == done_at + 1) rdy_after = lookup_ready;
      if (rst_at > 0 && n == rst_at + 1) rdy_post_rst = lookup_ready;
      lookup_req = (n == req2_at);
      if (n == req2_at) lookup_ip = 32'h1E00_0001;
      tbl_wr_req = (n == wr_at);
      if (n == wr_at) begin
        tbl_wr_addr = wa[4:0];
        tbl_wr_data = wd;
      end
      reset = (n == rst_at);
    end
  endtask

  task automatic read_all_f(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge AXI_ACLK);
      tbl_rd_req  = 1'b1;
      tbl_rd_addr = 5'(i);
      @(negedge AXI_ACLK);
      tbl_rd_req = 1'b0;
      n_cmp++;
      if (tbl_rd_ack !== 1'b1 || tbl_rd_data !== ALL_F) begin
        n_bad++;
        $display("FAIL %s rd[%0d]: ack=%b data=%h, want ack=1 data=%h", tag, i, tbl_rd_ack, tbl_rd_data, ALL_F);
      end
    end
    @(negedge AXI_ACLK);
    n_cmp++;
    if (tbl_rd_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rd_ack_drop: got %b want 0", tag, tbl_rd_ack);
    end
  endtask

  task automatic test_reset;
    int nd, da; logic ra, h, rp; logic [31:0] nh, oq;
    reset = 1'b1;
    repeat (2) @(negedge AXI_ACLK);
    n_cmp++;
    if ({lookup_ready, lookup_done, lpm_hit, tbl_wr_ack, tbl_rd_ack} !== 5'b10000 ||
        nh_out !== 32'd0 || oq_out !== 32'd0 || tbl_rd_data !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_state: rdy/done/hit/wack/rack=%b nh=%h oq=%h rd=%h, want 10000 0 0 0",
               {lookup_ready, lookup_done, lpm_hit, tbl_wr_ack, tbl_rd_ack}, nh_out, oq_out, tbl_rd_data);
    end
    reset = 1'b0;
    read_all_f("reset");
    run_lookup(32'h0A00_0001, 0, 0, 0, '0, 0, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (nd !== 1 || da !== 33 || ra !== 1'b1) begin
      n_bad++;
      $display("FAIL miss_latency: ndone=%0d at=%0d rdy=%b, want 1 33 1", nd, da, ra);
    end
    n_cmp++;
    if (h !== 1'b0 || nh !== 32'd0 || oq !== 32'd0) begin
      n_bad++;
      $display("FAIL miss_result: hit=%b nh=%h oq=%h, want 0 0 0", h, nh, oq);
    end
  endtask

  task automatic test_table_port;
    logic [127:0] e3;
    e3 = ent(32'h0A00_0000, 32'hFF00_0000, 32'h0, 32'd1);
    @(negedge AXI_ACLK);
    tbl_wr_req = 1'b1; tbl_wr_addr = 5'd3; tbl_wr_data = e3;
    tbl_rd_req = 1'b1; tbl_rd_addr = 5'd3;
    @(negedge AXI_ACLK);
    tbl_wr_req = 1'b0; tbl_rd_req = 1'b0;
    n_cmp++;
    if (tbl_wr_ack !== 1'b1 || tbl_rd_ack !== 1'b1 || tbl_rd_data !== ALL_F) begin
      n_bad++;
      $display("FAIL rw_same_addr: wack=%b rack=%b data=%h, want 1 1 %h", tbl_wr_ack, tbl_rd_ack, tbl_rd_data, ALL_F);
    end
    @(negedge AXI_ACLK);
    n_cmp++;
    if (tbl_wr_ack !== 1'b0 || tbl_rd_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_pulse: wack=%b rack=%b, want 0 0", tbl_wr_ack, tbl_rd_ack);
    end
    tbl_rd_req = 1'b1; tbl_rd_addr = 5'd3;
    @(negedge AXI_ACLK);
    tbl_rd_req = 1'b0;
    n_cmp++;
    if (tbl_rd_data !== e3) begin
      n_bad++;
      $display("FAIL readback3: got %h want %h", tbl_rd_data, e3);
    end
    wr(7, ent(32'h0A01_0000, 32'hFFFF_0000, 32'hC0A8_0101, 32'd2));
  endtask

  task automatic test_basic_match;
    int nd, da; logic ra, h, rp; logic [31:0] nh, oq;
    run_lookup(32'h0A01_0203, 0, 0, 0, '0, 0, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'hC0A8_0101 || oq !== 32'd2 || da !== 33) begin
      n_bad++;
      $display("FAIL lpm_16: hit=%b nh=%h oq=%h at=%0d, want 1 c0a80101 2 33", h, nh, oq, da);
    end
    run_lookup(32'h0A09_0909, 0, 0, 0, '0, 0, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'h0A09_0909 || oq !== 32'd1) begin
      n_bad++;
      $display("FAIL direct_8: hit=%b nh=%h oq=%h, want 1 0a090909 1", h, nh, oq);
    end
    @(negedge AXI_ACLK);
    n_cmp++;
    if (lpm_hit !== 1'b1 || nh_out !== 32'h0A09_0909 || oq_out !== 32'd1) begin
      n_bad++;
      $display("FAIL result_hold: hit=%b nh=%h oq=%h, want 1 0a090909 1", lpm_hit, nh_out, oq_out);
    end
  endtask

  task automatic test_default_route;
    int nd, da; logic ra, h, rp; logic [31:0] nh, oq;
    wr(0, ent(32'h0, 32'h0, 32'h0101_0101, 32'd4));
    wr(5, ent(32'h1400_0000, 32'hFF00_0000, 32'h0, 32'd3));
    run_lookup(32'h1E00_0001, 0, 0, 0, '0, 0, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'h0101_0101 || oq !== 32'd4) begin
      n_bad++;
      $display("FAIL default_route: hit=%b nh=%h oq=%h, want 1 01010101 4", h, nh, oq);
    end
  endtask

  task automatic test_tie;
    int nd, da; logic ra, h, rp; logic [31:0] nh, oq;
    wr(3, ALL_F);
    wr(7, ALL_F);
    wr(2, ent(32'h0A00_0000, 32'hFF00_0000, 32'h0, 32'd1));
    wr(9, ent(32'h0A00_0000, 32'hFF00_0000, 32'h0, 32'd3));
    run_lookup(32'h0A05_0505, 0, 0, 0, '0, 0, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'h0A05_0505 || oq !== 32'd1) begin
      n_bad++;
      $display("FAIL tie_low_index: hit=%b nh=%h oq=%h, want 1 0a050505 1", h, nh, oq);
    end
  endtask

  task automatic test_mid_scan;
    int nd, da; logic ra, h, rp; logic [31:0] nh, oq;
    // Stray request at T+5 with a different IP, plus a /32 write to an unscanned entry at T+10.
    run_lookup(32'h0A05_0505, 5, 10, 30, ent(32'h0A05_0505, 32'hFFFF_FFFF, 32'h0B0B_0B0B, 32'd7), 0,
               nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (nd !== 1 || da !== 33) begin
      n_bad++;
      $display("FAIL busy_req_ignored: ndone=%0d at=%0d, want 1 33", nd, da);
    end
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'h0B0B_0B0B || oq !== 32'd7) begin
      n_bad++;
      $display("FAIL write_unscanned: hit=%b nh=%h oq=%h, want 1 0b0b0b0b 7", h, nh, oq);
    end
    wr(30, ALL_F);
    run_lookup(32'h0A05_0505, 0, 10, 1, ent(32'h0A05_0505, 32'hFFFF_FFFF, 32'h0C0C_0C0C, 32'd6), 0,
               nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'h0A05_0505 || oq !== 32'd1) begin
      n_bad++;
      $display("FAIL write_scanned: hit=%b nh=%h oq=%h, want 1 0a050505 1", h, nh, oq);
    end
    run_lookup(32'h0A05_0505, 0, 0, 0, '0, 0, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (h !== 1'b1 || nh !== 32'h0C0C_0C0C || oq !== 32'd6) begin
      n_bad++;
      $display("FAIL write_landed: hit=%b nh=%h oq=%h, want 1 0c0c0c0c 6", h, nh, oq);
    end
  endtask

  task automatic test_reset_mid_scan;
    int nd, da; logic ra, h, rp; logic [31:0] nh, oq;
    run_lookup(32'h0A05_0505, 0, 0, 0, '0, 15, nd, da, ra, h, nh, oq, rp);
    n_cmp++;
    if (nd !== 0 || rp !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_abort: ndone=%0d rdy=%b, want 0 1", nd, rp);
    end
    n_cmp++;
    if (lpm_hit !== 1'b0 || nh_out !== 32'd0 || oq_out !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_result: hit=%b nh=%h oq=%h, want 0 0 0", lpm_hit, nh_out, oq_out);
    end
    read_all_f("midrst");
  endtask

  initial begin
    reset = 1'b0; lookup_req = 1'b0; lookup_ip = '0;
    tbl_wr_req = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    tbl_rd_req = 1'b0; tbl_rd_addr = '0;
    test_reset;
    test_table_port;
    test_basic_match;
    test_default_route;
    test_tie;
    test_mid_scan;
    test_reset_mid_scan;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
